// File: rtl/dmem_hs.sv
// Word-organised, byte-addressed little-endian data memory behind a valid/ready request port.
// Each accepted request gets exactly one response pulse after WAIT_STATES extra cycles; faults answer at once.
module dmem_hs #(
    parameter int                DEPTH_WORDS = 1024,
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_type,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);
    localparam int IW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [2:0]          r_type;
    logic [31:0]         r_wdata;
    logic                r_rsp_valid;
    logic                r_rsp_err;
    logic [31:0]         r_rsp_rdata;
    logic [31:0]         r_mem [DEPTH_WORDS];

    logic                w_idle;
    logic                w_hs;
    logic                w_we;
    logic [ADDR_W-1:0]   w_addr;
    logic [2:0]          w_type;
    logic [31:0]         w_wdata;
    logic [ADDR_W-1:0]   w_off;
    logic [1:0]          w_bo;
    logic [IW-1:0]       w_idx;
    logic                w_oor;
    logic                w_mis;
    logic                w_ill;
    logic                w_fault;
    logic                w_commit;
    logic [3:0]          w_be;
    logic [31:0]         w_wsh;

    function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] bo,
                                             input logic [2:0] t);
        logic [31:0] sh;
        sh = word >> {bo, 3'b000};
        case (t)
            3'b000:  load_ext = {{24{sh[7]}}, sh[7:0]};
            3'b001:  load_ext = {{16{sh[15]}}, sh[15:0]};
            3'b100:  load_ext = {24'h0, sh[7:0]};
            3'b101:  load_ext = {16'h0, sh[15:0]};
            default: load_ext = sh;
        endcase
    endfunction

    assign w_idle    = (r_state == S_IDLE);
    assign req_ready = w_idle && rst_n;
    assign w_hs      = req_valid && req_ready;
    assign busy      = !w_idle;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

    // In IDLE the request port itself is the transaction; afterwards the captured copy is.
    assign w_we    = w_idle ? req_we    : r_we;
    assign w_addr  = w_idle ? req_addr  : r_addr;
    assign w_type  = w_idle ? req_type  : r_type;
    assign w_wdata = w_idle ? req_wdata : r_wdata;

    assign w_off   = w_addr - BASE_ADDR;
    assign w_bo    = w_addr[1:0];
    assign w_idx   = w_off[IW+1:2];
    assign w_oor   = (w_addr < BASE_ADDR) || ((w_off >> 2) >= ADDR_W'(DEPTH_WORDS));
    assign w_mis   = ((w_type[1:0] == 2'b01) && w_bo[0]) || ((w_type[1:0] == 2'b10) && (w_bo != 2'b00));
    assign w_ill   = (w_type == 3'b011) || (w_type[2:1] == 2'b11) || (w_type[2] && w_we);
    assign w_fault = w_oor || w_mis || w_ill;

    // Edge that enters RESP: memory access and response are both resolved here.
    assign w_commit = (w_hs && (w_fault || (WAIT_STATES == 0))) ||
                      ((r_state == S_WAIT) && (r_cnt == 4'(WAIT_STATES - 1)));

    always_comb begin
        case (w_type[1:0])
            2'b00:   w_be = 4'b0001 << w_bo;
            2'b01:   w_be = 4'b0011 << w_bo;
            default: w_be = 4'b1111;
        endcase
    end
    assign w_wsh = w_wdata << {w_bo, 3'b000};

    always_ff @(posedge clk) begin
        if (w_hs) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_type  <= req_type;
            r_wdata <= req_wdata;
        end
    end

    // A commit edge that coincides with reset must not write.
    always_ff @(posedge clk) begin
        if (rst_n && w_commit && w_we && !w_fault) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wsh[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= 4'd0;
                    if (w_hs) r_state <= w_commit ? S_RESP : S_WAIT;
                end
                S_WAIT: begin
                    if (w_commit) r_state <= S_RESP;
                    else          r_cnt   <= r_cnt + 4'd1;
                end
                default: r_state <= S_IDLE;
            endcase
            if (w_commit) begin
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= w_fault;
                r_rsp_rdata <= (w_fault || w_we) ? 32'h0 : load_ext(r_mem[w_idx], w_bo, w_type);
            end
        end
    end
endmodule

// File: tb/tb_dmem_hs.sv
// Directed bench for dmem_hs: four instances cover WAIT_STATES 1/0/3 and a non-zero BASE_ADDR.
module tb_dmem_hs;
    localparam logic [2:0] T_B = 3'b000, T_H = 3'b001, T_W = 3'b010, T_BU = 3'b100, T_HU = 3'b101;

    logic        clk = 1'b0;
    logic        rst_n     [4];
    logic        req_valid [4];
    logic        req_ready [4];
    logic        req_we    [4];
    logic [31:0] req_addr  [4];
    logic [2:0]  req_type  [4];
    logic [31:0] req_wdata [4];
    logic        rsp_valid [4];
    logic [31:0] rsp_rdata [4];
    logic        rsp_err   [4];
    logic        busy      [4];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        dmem_hs #(
            .DEPTH_WORDS(64),
            .ADDR_W     (32),
            .BASE_ADDR  ((g == 3) ? 32'h8000_0000 : 32'h0),
            .WAIT_STATES((g == 1) ? 0 : ((g == 2) ? 3 : 1))
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n[g]),
            .req_valid(req_valid[g]),
            .req_ready(req_ready[g]),
            .req_we   (req_we[g]),
            .req_addr (req_addr[g]),
            .req_type (req_type[g]),
            .req_wdata(req_wdata[g]),
            .rsp_valid(rsp_valid[g]),
            .rsp_rdata(rsp_rdata[g]),
            .rsp_err  (rsp_err[g]),
            .busy     (busy[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One request on instance d: checks acceptance, latency, pulse width and ready recovery.
    task automatic op(input int d, input logic we, input logic [31:0] addr, input logic [2:0] t,
                      input logic [31:0] wd, input int exp_lat, input logic exp_err,
                      input logic [31:0] exp_rd, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_type[d]  = t;
        req_wdata[d] = wd;
        while (!req_ready[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_acc"}, 32'(req_ready[d]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid[d] = 1'b0;
        n = 1;
        while (!rsp_valid[d] && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, n, exp_lat);
        chk({tag, "_err"}, 32'(rsp_err[d]), 32'(exp_err));
        chk({tag, "_rd"}, rsp_rdata[d], exp_rd);
        chk({tag, "_rdyrsp"}, 32'(req_ready[d]), 32'd0);
        @(negedge clk);
        chk({tag, "_vldoff"}, 32'(rsp_valid[d]), 32'd0);
        chk({tag, "_rdyback"}, 32'(req_ready[d]), 32'd1);
    endtask

    // req_valid held high for ncyc cycles; per-cycle busy/rsp_valid against the accept timeline.
    task automatic btb(input int d, input int ws, input int ncyc, input int exp_acc, input string tag);
        int last, nacc, nrsp, k;
        last = -100;
        nacc = 0;
        nrsp = 0;
        @(negedge clk);
        req_valid[d] = 1'b1;
        req_we[d]    = 1'b0;
        req_addr[d]  = 32'h0;
        req_type[d]  = T_W;
        req_wdata[d] = 32'h0;
        for (int c = 0; c < ncyc; c++) begin
            k = c - last;
            chk({tag, "_busy"}, 32'(busy[d]), 32'((k >= 1) && (k <= 1 + ws)));
            chk({tag, "_vld"}, 32'(rsp_valid[d]), 32'(k == 1 + ws));
            if (rsp_valid[d]) begin
                nrsp++;
                chk({tag, "_err"}, 32'(rsp_err[d]), 32'd0);
            end
            if (req_valid[d] && req_ready[d]) begin
                if (nacc > 0) chk({tag, "_space"}, k, 2 + ws);
                last = c;
                nacc++;
            end
            @(negedge clk);
        end
        req_valid[d] = 1'b0;
        for (int c = 0; c < ws + 3; c++) begin
            if (rsp_valid[d]) nrsp++;
            @(negedge clk);
        end
        chk({tag, "_nacc"}, nacc, exp_acc);
        chk({tag, "_nrsp"}, nrsp, nacc);
    endtask

    initial begin
        int nr;
        for (int i = 0; i < 4; i++) begin
            rst_n[i]     = 1'b0;
            req_valid[i] = 1'b0;
            req_we[i]    = 1'b0;
            req_addr[i]  = 32'h0;
            req_type[i]  = T_W;
            req_wdata[i] = 32'h0;
        end
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(req_ready[0]), 32'd0);
        chk("rst_vld", 32'(rsp_valid[0]), 32'd0);
        chk("rst_busy", 32'(busy[0]), 32'd0);
        chk("rst_rd", rsp_rdata[0], 32'h0);
        chk("rst_err", 32'(rsp_err[0]), 32'd0);
        for (int i = 0; i < 4; i++) rst_n[i] = 1'b1;
        #1;
        chk("rel_ready", 32'(req_ready[0]), 32'd1);

        op(0, 1'b1, 32'h10, T_W, 32'hDEADBEEF, 2, 1'b0, 32'h0, "sw10");
        op(0, 1'b0, 32'h10, T_W, 32'h0, 2, 1'b0, 32'hDEADBEEF, "lw10");

        op(0, 1'b1, 32'h11, T_B, 32'hFFFFFF7F, 2, 1'b0, 32'h0, "sb11");
        op(0, 1'b0, 32'h10, T_W, 32'h0, 2, 1'b0, 32'hDEAD7FEF, "lw10b");
        op(0, 1'b0, 32'h13, T_B, 32'h0, 2, 1'b0, 32'hFFFFFFDE, "lb13");
        op(0, 1'b0, 32'h13, T_BU, 32'h0, 2, 1'b0, 32'h000000DE, "lbu13");
        op(0, 1'b0, 32'h12, T_H, 32'h0, 2, 1'b0, 32'hFFFFDEAD, "lh12");
        op(0, 1'b0, 32'h12, T_HU, 32'h0, 2, 1'b0, 32'h0000DEAD, "lhu12");

        op(0, 1'b0, 32'h12, T_W, 32'h0, 1, 1'b1, 32'h0, "f_lwmis");
        op(0, 1'b1, 32'h11, T_H, 32'h1111, 1, 1'b1, 32'h0, "f_shmis");
        op(0, 1'b0, 32'h10, 3'b011, 32'h0, 1, 1'b1, 32'h0, "f_t011");
        op(0, 1'b1, 32'h10, T_BU, 32'h55, 1, 1'b1, 32'h0, "f_sbu");
        op(0, 1'b0, 32'h100, T_W, 32'h0, 1, 1'b1, 32'h0, "f_oor");
        op(0, 1'b1, 32'h10, 3'b111, 32'h0, 1, 1'b1, 32'h0, "f_t111");
        op(0, 1'b0, 32'h10, T_W, 32'h0, 2, 1'b0, 32'hDEAD7FEF, "lw10c");

        btb(1, 0, 20, 10, "b2b_ws0");
        btb(2, 3, 20, 4, "b2b_ws3");

        op(2, 1'b1, 32'h20, T_W, 32'hCAFEF00D, 4, 1'b0, 32'h0, "sw20a");
        op(2, 1'b0, 32'h20, T_W, 32'h0, 4, 1'b0, 32'hCAFEF00D, "lw20a");
        @(negedge clk);
        req_valid[2] = 1'b1;
        req_we[2]    = 1'b1;
        req_addr[2]  = 32'h20;
        req_type[2]  = T_W;
        req_wdata[2] = 32'h12345678;
        chk("rmo_acc", 32'(req_ready[2]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid[2] = 1'b0;
        @(negedge clk);
        rst_n[2] = 1'b0;
        @(negedge clk);
        rst_n[2] = 1'b1;
        #1;
        chk("rmo_busy", 32'(busy[2]), 32'd0);
        chk("rmo_ready", 32'(req_ready[2]), 32'd1);
        nr = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (rsp_valid[2]) nr++;
        end
        chk("rmo_norsp", nr, 0);
        op(2, 1'b0, 32'h20, T_W, 32'h0, 4, 1'b0, 32'hCAFEF00D, "lw20b");

        op(3, 1'b0, 32'h7FFF_FFFC, T_W, 32'h0, 1, 1'b1, 32'h0, "bs_below");
        op(3, 1'b1, 32'h8000_0004, T_W, 32'hA5A51234, 2, 1'b0, 32'h0, "bs_sw");
        op(3, 1'b0, 32'h8000_0004, T_W, 32'h0, 2, 1'b0, 32'hA5A51234, "bs_lw");
        op(3, 1'b0, 32'h8000_0100, T_W, 32'h0, 1, 1'b1, 32'h0, "bs_above");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
